// File: rtl/decryption_pkg.sv
// Shared constants and FIFO entry type for the decryption datapath.
// The packer imports these so character width, terminator and word layout agree.
package decryption_pkg;

   localparam int unsigned SYS_DWIDTH = 8;
   localparam int unsigned MST_DWIDTH = 4 * SYS_DWIDTH;

   localparam logic [SYS_DWIDTH-1:0] TERM_CHAR = 8'hFA;
   localparam logic [SYS_DWIDTH-1:0] PAD_BYTE  = 8'h00;

   typedef struct packed {
      logic                  last;
      logic [MST_DWIDTH-1:0] word;
   } fifo_entry_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO of packed {last, word} entries with synchronous active-low reset.
// Pointers wrap modulo DEPTH; count is one bit wider so full and empty are distinct.
module word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/decryption_word_packer.sv
// Packs one ciphertext character per cycle into 32-bit words (first char in MSBs),
// buffers them, and hands each word to decryption_top only while busy_i is low.
module decryption_word_packer #(
   parameter int unsigned MST_DWIDTH = 32,
   parameter int unsigned SYS_DWIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SYS_DWIDTH-1:0] char_i,
   input  logic                  char_valid_i,
   output logic                  char_ready_o,
   input  logic                  busy_i,
   output logic [MST_DWIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  last_o
);

   import decryption_pkg::*;

   localparam int unsigned LANES = MST_DWIDTH / SYS_DWIDTH;
   localparam int unsigned LW    = $clog2(LANES);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

   logic [LW-1:0]         lane;
   logic [MST_DWIDTH-1:0] asm_word;
   logic [MST_DWIDTH-1:0] packed_word;
   logic                  accept;
   logic                  is_term;
   logic                  complete;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic [CW-1:0]         fifo_count;
   fifo_entry_t           push_entry;
   fifo_entry_t           head_entry;

   // Ready looks only at the registered count, so a pop on a full FIFO frees no slot this cycle.
   assign char_ready_o = rst_n && (fifo_count < CW'(FIFO_DEPTH));
   assign accept       = char_valid_i && char_ready_o;
   assign is_term      = (char_i == TERM_CHAR);
   assign complete     = accept && (is_term || (lane == LW'(LANES - 1)));
   assign fifo_pop     = !fifo_empty && !busy_i;

   // Earlier lanes come from the assembly register, later ones are padded.
   always_comb begin
      packed_word = '0;
      for (int unsigned b = 0; b < LANES; b++) begin
         if (b < 32'(lane))
            packed_word[(LANES-1-b)*SYS_DWIDTH +: SYS_DWIDTH] = asm_word[(LANES-1-b)*SYS_DWIDTH +: SYS_DWIDTH];
         else if (b == 32'(lane))
            packed_word[(LANES-1-b)*SYS_DWIDTH +: SYS_DWIDTH] = char_i;
         else
            packed_word[(LANES-1-b)*SYS_DWIDTH +: SYS_DWIDTH] = PAD_BYTE;
      end
   end

   assign push_entry.last = is_term;
   assign push_entry.word = packed_word;

   word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (complete && !fifo_full),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane     <= '0;
         asm_word <= '0;
         data_o   <= '0;
         valid_o  <= 1'b0;
         last_o   <= 1'b0;
      end else begin
         if (accept) begin
            if (complete) begin
               lane     <= '0;
               asm_word <= '0;
            end else begin
               lane     <= lane + 1'b1;
               asm_word <= packed_word;
            end
         end
         valid_o <= fifo_pop;
         if (fifo_pop) begin
            data_o <= head_entry.word;
            last_o <= head_entry.last;
         end
      end
   end

endmodule

// File: tb/tb_decryption_word_packer.sv
// Scoreboard bench: a byte-queue reference model predicts words and pops,
// and a negedge monitor compares every output cycle against it.
module tb_decryption_word_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  char_i = '0;
   logic        char_valid_i = 1'b0;
   logic        busy_i = 1'b0;
   logic        char_ready_o;
   logic [31:0] data_o;
   logic        valid_o;
   logic        last_o;

   always #5 clk = ~clk;

   decryption_word_packer #(
      .MST_DWIDTH (32),
      .SYS_DWIDTH (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .char_i       (char_i),
      .char_valid_i (char_valid_i),
      .char_ready_o (char_ready_o),
      .busy_i       (busy_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .last_o       (last_o)
   );

   typedef struct {
      logic        last;
      logic [31:0] word;
   } exp_t;

   exp_t       words_q[$];
   exp_t       out_q[$];
   logic [7:0] part_q[$];
   bit         rst_edge = 1'b0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: characters collect in a list; four of them or a terminator form a word.
   always @(posedge clk) begin : model
      exp_t w;
      bit   ready;
      if (!rst_n) begin
         words_q.delete();
         out_q.delete();
         part_q.delete();
         rst_edge = 1'b1;
      end else begin
         rst_edge = 1'b0;
         ready = (words_q.size() < 4);
         if (words_q.size() != 0 && !busy_i)
            out_q.push_back(words_q.pop_front());
         if (char_valid_i && ready) begin
            part_q.push_back(char_i);
            if (part_q.size() == 4 || char_i == 8'hFA) begin
               w.word = '0;
               for (int i = 0; i < part_q.size(); i++)
                  w.word[31-8*i -: 8] = part_q[i];
               w.last = (char_i == 8'hFA);
               words_q.push_back(w);
               part_q.delete();
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      exp_t hold;
      bit   exp_valid;
      bit   exp_ready;
      if (rst_edge) begin
         hold.word = '0;
         hold.last = 1'b0;
      end
      exp_ready = rst_n && (words_q.size() < 4);
      chk("char_ready", 64'(char_ready_o), 64'(exp_ready));
      exp_valid = (out_q.size() != 0);
      chk("valid", 64'(valid_o), 64'(exp_valid));
      if (exp_valid) begin
         e    = out_q.pop_front();
         hold = e;
      end
      chk("data", 64'(data_o), 64'(hold.word));
      chk("last", 64'(last_o), 64'(hold.last));
   end

   task automatic drive(input bit v, input logic [7:0] c, input bit b);
      @(posedge clk);
      #1;
      char_valid_i = v;
      char_i       = c;
      busy_i       = b;
   endtask

   task automatic idle(input int n, input bit b);
      repeat (n) drive(1'b0, 8'h00, b);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      char_valid_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // basic packing
      drive(1, 8'h41, 0); drive(1, 8'h42, 0); drive(1, 8'h43, 0); drive(1, 8'h44, 0);
      idle(4, 0);

      // terminator padding, then a lone terminator
      drive(1, 8'h41, 0); drive(1, 8'h42, 0); drive(1, 8'hFA, 0);
      idle(3, 0);
      drive(1, 8'hFA, 0);
      idle(4, 0);

      // backpressure: 20 characters offered while busy
      for (int i = 0; i < 20; i++) drive(1, 8'(8'h60 + i), 1);
      idle(8, 0);

      // reset mid-word
      drive(1, 8'h41, 0); drive(1, 8'h42, 0);
      pulse_reset();
      drive(1, 8'h51, 0); drive(1, 8'h52, 0); drive(1, 8'h53, 0); drive(1, 8'h54, 0);
      idle(4, 0);

      // full FIFO: busy drops in the same cycle as a held character
      for (int i = 0; i < 16; i++) drive(1, 8'(8'h70 + i), 1);
      drive(1, 8'h81, 0);
      drive(1, 8'h81, 0);
      drive(1, 8'h82, 0); drive(1, 8'h83, 0); drive(1, 8'hFA, 0);
      idle(8, 0);

      // randomized traffic with occasional resets and busy bursts
      for (int n = 0; n < 1200; n++) begin
         if ($urandom_range(0, 249) == 0) begin
            pulse_reset();
         end else begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 8'hFA : 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 3));
         end
      end

      idle(12, 0);
      checks++;
      if (out_q.size() != 0 || words_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d words still expected, required 0", out_q.size() + words_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
